// File: rtl/msg_seq_pkg.sv
// Shared definitions for the 7-segment message path.
//
// Holds the sequencer state type, the default character code width and the
// character code map. The same codes are decoded by the downstream
// char-to-segment encoder, so the two must stay in lock-step.
//
// Code map: 0 = blank, 1 = decimal point, 2..27 = letters A..Z.

package msg_seq_pkg;

    localparam int unsigned MSG_CHAR_W = 5;

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StGap
    } msg_state_e;

    localparam logic [MSG_CHAR_W-1:0] CH_BLANK = 5'd0;
    localparam logic [MSG_CHAR_W-1:0] CH_DP    = 5'd1;
    localparam logic [MSG_CHAR_W-1:0] CH_A     = 5'd2;
    localparam logic [MSG_CHAR_W-1:0] CH_B     = 5'd3;
    localparam logic [MSG_CHAR_W-1:0] CH_C     = 5'd4;
    localparam logic [MSG_CHAR_W-1:0] CH_D     = 5'd5;
    localparam logic [MSG_CHAR_W-1:0] CH_E     = 5'd6;
    localparam logic [MSG_CHAR_W-1:0] CH_F     = 5'd7;
    localparam logic [MSG_CHAR_W-1:0] CH_G     = 5'd8;
    localparam logic [MSG_CHAR_W-1:0] CH_H     = 5'd9;
    localparam logic [MSG_CHAR_W-1:0] CH_I     = 5'd10;
    localparam logic [MSG_CHAR_W-1:0] CH_J     = 5'd11;
    localparam logic [MSG_CHAR_W-1:0] CH_K     = 5'd12;
    localparam logic [MSG_CHAR_W-1:0] CH_L     = 5'd13;
    localparam logic [MSG_CHAR_W-1:0] CH_M     = 5'd14;
    localparam logic [MSG_CHAR_W-1:0] CH_N     = 5'd15;
    localparam logic [MSG_CHAR_W-1:0] CH_O     = 5'd16;
    localparam logic [MSG_CHAR_W-1:0] CH_P     = 5'd17;
    localparam logic [MSG_CHAR_W-1:0] CH_Q     = 5'd18;
    localparam logic [MSG_CHAR_W-1:0] CH_R     = 5'd19;
    localparam logic [MSG_CHAR_W-1:0] CH_S     = 5'd20;
    localparam logic [MSG_CHAR_W-1:0] CH_T     = 5'd21;
    localparam logic [MSG_CHAR_W-1:0] CH_U     = 5'd22;
    localparam logic [MSG_CHAR_W-1:0] CH_V     = 5'd23;
    localparam logic [MSG_CHAR_W-1:0] CH_W     = 5'd24;
    localparam logic [MSG_CHAR_W-1:0] CH_X     = 5'd25;
    localparam logic [MSG_CHAR_W-1:0] CH_Y     = 5'd26;
    localparam logic [MSG_CHAR_W-1:0] CH_Z     = 5'd27;

endpackage

// File: rtl/msg_sequencer_prescaler.sv
// msg_prescaler: tick generator for the message sequencer.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          count enable; counter held at 0 while low
//   clear       synchronous counter clear
//   div         tick period minus 1, in clk cycles
//   tick        high in every cycle where cnt >= div
//
// The >= compare (not ==) means a div that shrinks below the running count
// produces an immediate tick instead of waiting for the counter to wrap.

module msg_prescaler #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q >= div);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || !en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/msg_sequencer.sv
// msg_sequencer: steps through a host-loaded message of character codes.
//
// Each character is shown for SHOW_TICKS prescaler ticks, followed by
// GAP_TICKS blank ticks so repeated letters stay distinguishable. The
// current code feeds the downstream char-to-segment encoder.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   run         enable sequencing; low forces IDLE with index 0
//   clr         empty the buffer, clear overflow, force IDLE (beats wr_en)
//   wr_en       append wr_data at mem[length]
//   wr_data     character code to append
//   div         prescaler tick period minus 1
//   char_code   current character (held during the gap)
//   blank       1 = display off
//   step        pulse in the first cycle a character is shown
//   wrap        pulse with step when index 0 starts
//   overflow    sticky: a write hit a full buffer
//   length      number of stored characters
//
// Optional build macro MSG_SEQUENCER_ONESHOT_EN adds:
//   oneshot     stop after the last character instead of wrapping
//   done        set when a one-shot pass finishes; cleared by run low or clr
//
// All outputs come straight from registers.

module msg_sequencer
    import msg_seq_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CHAR_W     = MSG_CHAR_W,
    parameter int unsigned DIV_W      = 24,
    parameter int unsigned SHOW_TICKS = 4,
    parameter int unsigned GAP_TICKS  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic                    clr,
    input  logic                    wr_en,
    input  logic [CHAR_W-1:0]       wr_data,
    input  logic [DIV_W-1:0]        div,
`ifdef MSG_SEQUENCER_ONESHOT_EN
    input  logic                    oneshot,
    output logic                    done,
`endif
    output logic [CHAR_W-1:0]       char_code,
    output logic                    blank,
    output logic                    step,
    output logic                    wrap,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  length
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned LEN_W  = $clog2(DEPTH) + 1;
    localparam int unsigned TMAX   = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
    localparam int unsigned TCNT_W = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TCNT_W-1:0] SHOW_LAST = TCNT_W'(SHOW_TICKS - 1);
    localparam logic [TCNT_W-1:0] GAP_LAST  = TCNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [LEN_W-1:0]  FULL      = LEN_W'(DEPTH);

    // Message buffer
    logic [CHAR_W-1:0] mem_q [DEPTH];
    logic [LEN_W-1:0]  length_q;
    logic              overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            length_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clr) begin
            length_q   <= '0;
            overflow_q <= 1'b0;
        end else if (wr_en) begin
            if (length_q == FULL) begin
                overflow_q <= 1'b1;
            end else begin
                mem_q[length_q[IDX_W-1:0]] <= wr_data;
                length_q                   <= length_q + 1'b1;
            end
        end
    end

    // Sequencer state
    msg_state_e        state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [CHAR_W-1:0] char_code_q, char_code_d;
    logic              blank_q, blank_d;
    logic              step_q, step_d;
    logic              wrap_q, wrap_d;

    logic              tick;
    logic              advance;
    logic              start_show;
    logic              oneshot_stop;
    logic              hold_idle;
    logic              stop_at_end;
    logic [LEN_W-1:0]  idx_inc;
    logic              is_last;

`ifdef MSG_SEQUENCER_ONESHOT_EN
    logic done_q, done_d;

    assign hold_idle   = done_q;
    assign stop_at_end = oneshot;
    assign done        = done_q;

    always_comb begin
        done_d = done_q;
        if (clr || !run) begin
            done_d = 1'b0;
        end else if (oneshot_stop) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end
`else
    assign hold_idle   = 1'b0;
    assign stop_at_end = 1'b0;
`endif

    // Compare against the live length so a shrunken message restarts at 0
    assign idx_inc = LEN_W'(index_q) + LEN_W'(1);
    assign is_last = (idx_inc >= length_q);

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        tcnt_d       = tcnt_q;
        char_code_d  = char_code_q;
        step_d       = 1'b0;
        wrap_d       = 1'b0;
        advance      = 1'b0;
        start_show   = 1'b0;
        oneshot_stop = 1'b0;

        if (clr || !run || (length_q == '0)) begin
            state_d = StIdle;
            index_d = '0;
            tcnt_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (!hold_idle) begin
                        start_show = 1'b1;
                        index_d    = '0;
                    end
                end
                StShow: begin
                    if (tick) begin
                        if (tcnt_q == SHOW_LAST) begin
                            tcnt_d = '0;
                            if (GAP_TICKS == 0) begin
                                advance = 1'b1;
                            end else begin
                                state_d = StGap;
                            end
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                end
                StGap: begin
                    if (tick) begin
                        if (tcnt_q == GAP_LAST) begin
                            tcnt_d  = '0;
                            advance = 1'b1;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    index_d = '0;
                    tcnt_d  = '0;
                end
            endcase

            if (advance) begin
                if (stop_at_end && is_last) begin
                    oneshot_stop = 1'b1;
                    state_d      = StIdle;
                    index_d      = '0;
                end else begin
                    start_show = 1'b1;
                    index_d    = is_last ? '0 : index_q + 1'b1;
                end
            end
        end

        if (start_show) begin
            state_d     = StShow;
            step_d      = 1'b1;
            wrap_d      = (index_d == '0);
            char_code_d = mem_q[index_d];
        end

        blank_d = (state_d != StShow);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            index_q     <= '0;
            tcnt_q      <= '0;
            char_code_q <= '0;
            blank_q     <= 1'b1;
            step_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            tcnt_q      <= tcnt_d;
            char_code_q <= char_code_d;
            blank_q     <= blank_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
        end
    end

    // Prescaler is held at 0 in IDLE, so SHOW always starts with a fresh count
    msg_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q != StIdle),
        .clear (state_d == StIdle),
        .div   (div),
        .tick  (tick)
    );

    assign char_code = char_code_q;
    assign blank     = blank_q;
    assign step      = step_q;
    assign wrap      = wrap_q;
    assign overflow  = overflow_q;
    assign length    = length_q;

endmodule
